// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer beside the ID/EX boundary: merges memory-wait, mul/div,
// taken-branch and load-use hazards into pipeline enables, bubbles and flushes.
module pipeline_stall_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rd_ex,
    input  logic             MemRead_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic             muldiv_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             load_delay,
    output logic             ex_bubble,
    output logic             muldiv_done,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;
    // MD_LAT of 1 means mul/div finishes inside the normal EX slot
    localparam bit MD_EN = (MD_LAT >= 2);
    localparam logic [CW-1:0]    MD_INIT = CW'(MD_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [CW-1:0]    md_cnt_r;
    logic [CW-1:0]    md_cnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;

    logic freeze_s;
    logic lu_s;
    logic pc_write_s;
    logic if_id_write_s;
    logic id_ex_write_s;
    logic ex_mem_write_s;
    logic if_id_flush_s;
    logic load_delay_s;
    logic ex_bubble_s;
    logic muldiv_done_s;

    assign freeze_s = dmem_req_mem & ~dmem_ready;
    // x0 is deliberately not excluded: a load to x0 still stalls its consumer
    assign lu_s = MemRead_ex & ((use_rs1_id & (rs1_id == rd_ex)) |
                                (use_rs2_id & (rs2_id == rd_ex)));

    // Hazard priority resolution and next-state selection
    always_comb begin
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        id_ex_write_s  = 1'b1;
        ex_mem_write_s = 1'b1;
        if_id_flush_s  = 1'b0;
        load_delay_s   = 1'b0;
        ex_bubble_s    = 1'b0;
        muldiv_done_s  = 1'b0;
        state_nxt_s    = state_r;
        md_cnt_nxt_s   = md_cnt_r;
        if (reset) begin
            state_nxt_s  = ST_RUN;
            md_cnt_nxt_s = '0;
        end else if (freeze_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_write_s  = 1'b0;
            ex_mem_write_s = 1'b0;
        end else if (state_r == ST_MD_BUSY) begin
            if (md_cnt_r != '0) begin
                pc_write_s    = 1'b0;
                if_id_write_s = 1'b0;
                id_ex_write_s = 1'b0;
                ex_bubble_s   = 1'b1;
                md_cnt_nxt_s  = md_cnt_r - CW'(1);
            end else begin
                muldiv_done_s = 1'b1;
                state_nxt_s   = ST_RUN;
            end
        end else if (muldiv_ex && MD_EN) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            id_ex_write_s = 1'b0;
            ex_bubble_s   = 1'b1;
            state_nxt_s   = ST_MD_BUSY;
            md_cnt_nxt_s  = MD_INIT;
        end else if (branch_taken_ex) begin
            if_id_flush_s = 1'b1;
            load_delay_s  = 1'b1;
        end else if (lu_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            load_delay_s  = 1'b1;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM, mul/div countdown and saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RUN;
            md_cnt_r    <= '0;
            stall_cnt_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            md_cnt_r <= md_cnt_nxt_s;
            if (!pc_write_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
        end
    end

    assign PCWrite      = pc_write_s;
    assign IF_ID_Write  = if_id_write_s;
    assign ID_EX_Write  = id_ex_write_s;
    assign EX_MEM_Write = ex_mem_write_s;
    assign IF_ID_Flush  = if_id_flush_s;
    assign load_delay   = load_delay_s;
    assign ex_bubble    = ex_bubble_s;
    assign muldiv_done  = muldiv_done_s;
    assign md_busy      = ~reset & (state_r == ST_MD_BUSY);
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: vector table with a scoreboard of
// expected outputs, plus a bounded wait for the mul/div completion pulse.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic MemRead_ex, use_rs1_id, use_rs2_id, muldiv_ex, branch_taken_ex;
    logic dmem_req_mem, dmem_ready;

    logic PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush;
    logic load_delay, ex_bubble, muldiv_done, md_busy;
    logic [15:0] stall_cycles;

    logic w_PCWrite, w_IF_ID_Write, w_ID_EX_Write, w_EX_MEM_Write, w_IF_ID_Flush;
    logic w_load_delay, w_ex_bubble, w_muldiv_done, w_md_busy;
    logic [3:0] w_stall_cycles;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MD_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .muldiv_ex(muldiv_ex), .branch_taken_ex(branch_taken_ex),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
        .EX_MEM_Write(EX_MEM_Write), .IF_ID_Flush(IF_ID_Flush), .load_delay(load_delay),
        .ex_bubble(ex_bubble), .muldiv_done(muldiv_done), .md_busy(md_busy),
        .stall_cycles(stall_cycles)
    );

    pipeline_stall_ctrl #(.MD_LAT(4), .CNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .muldiv_ex(muldiv_ex), .branch_taken_ex(branch_taken_ex),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .PCWrite(w_PCWrite), .IF_ID_Write(w_IF_ID_Write), .ID_EX_Write(w_ID_EX_Write),
        .EX_MEM_Write(w_EX_MEM_Write), .IF_ID_Flush(w_IF_ID_Flush), .load_delay(w_load_delay),
        .ex_bubble(w_ex_bubble), .muldiv_done(w_muldiv_done), .md_busy(w_md_busy),
        .stall_cycles(w_stall_cycles)
    );

    // Output vector order: PCWrite IF_ID_Write ID_EX_Write EX_MEM_Write
    //                      IF_ID_Flush load_delay ex_bubble muldiv_done md_busy
    localparam logic [8:0] O_IDLE  = 9'b1111_0000_0;
    localparam logic [8:0] O_LU    = 9'b0011_0100_0;
    localparam logic [8:0] O_BR    = 9'b1111_1100_0;
    localparam logic [8:0] O_MDST  = 9'b0001_0010_0;
    localparam logic [8:0] O_MDBSY = 9'b0001_0010_1;
    localparam logic [8:0] O_DONE  = 9'b1111_0001_1;
    localparam logic [8:0] O_FRZ   = 9'b0000_0000_0;
    localparam logic [8:0] O_FRZB  = 9'b0000_0000_1;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       md;
        logic       br;
        logic       dreq;
        logic       drdy;
        logic [8:0] exp;
    } vec_t;

    typedef struct {
        int          idx;
        logic [8:0]  outs;
        logic        chk_st;
        logic [15:0] st16;
        logic [3:0]  st4;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] m16;
    logic [3:0]  m4;
    logic        st_known;

    function automatic vec_t mk(input logic rst, input logic mr, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic md,
                                input logic br, input logic dreq, input logic drdy,
                                input logic [8:0] exp);
        vec_t v;
        v.rst = rst; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.md = md; v.br = br; v.dreq = dreq; v.drdy = drdy;
        v.exp = exp;
        return v;
    endfunction

    function automatic vec_t quiet(input logic rst, input logic md, input logic dreq,
                                   input logic [8:0] exp);
        return mk(rst, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, md, 1'b0, dreq, 1'b0, exp);
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; MemRead_ex = v.mr; rd_ex = v.rd; rs1_id = v.rs1; rs2_id = v.rs2;
        use_rs1_id = v.u1; use_rs2_id = v.u2; muldiv_ex = v.md; branch_taken_ex = v.br;
        dmem_req_mem = v.dreq; dmem_ready = v.drdy;
    endtask

    task automatic check_entry(input sb_t e);
        logic [8:0] act;
        act = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush,
               load_delay, ex_bubble, muldiv_done, md_busy};
        checks++;
        if (act !== e.outs) begin
            errors++;
            $display("FAIL outs[%0d]: got %b expected %b", e.idx, act, e.outs);
        end
        if (e.chk_st) begin
            checks++;
            if (stall_cycles !== e.st16) begin
                errors++;
                $display("FAIL stall16[%0d]: got %0d expected %0d", e.idx, stall_cycles, e.st16);
            end
            checks++;
            if (w_stall_cycles !== e.st4) begin
                errors++;
                $display("FAIL stall4[%0d]: got %0d expected %0d", e.idx, w_stall_cycles, e.st4);
            end
        end
    endtask

    initial begin
        drive(quiet(1'b1, 1'b0, 1'b0, O_IDLE));
        st_known = 1'b0;
        m16 = 16'd0;
        m4  = 4'd0;

        tbl.push_back(quiet(1'b1, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(quiet(1'b1, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(mk(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
        tbl.push_back(mk(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(mk(1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
        tbl.push_back(mk(1'b0, 1'b1, 5'd7, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
        tbl.push_back(mk(1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(mk(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_BR));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR));
        tbl.push_back(mk(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_FRZ));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_IDLE));
        // mul/div from a fresh counter: done in cycle 3 with stall_cycles 3
        tbl.push_back(quiet(1'b1, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(quiet(1'b0, 1'b1, 1'b0, O_MDST));
        tbl.push_back(mk(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_MDBSY));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_MDBSY));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_DONE));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_IDLE));
        // two freeze cycles at md_cnt=1 push done to cycle 5, stall_cycles 5
        tbl.push_back(quiet(1'b1, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(quiet(1'b0, 1'b1, 1'b0, O_MDST));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_MDBSY));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b1, O_FRZB));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b1, O_FRZB));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_MDBSY));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_DONE));
        // freeze landing on the completion cycle delays the done pulse
        tbl.push_back(quiet(1'b0, 1'b1, 1'b0, O_MDST));
        tbl.push_back(quiet(1'b0, 1'b1, 1'b0, O_MDBSY));
        tbl.push_back(quiet(1'b0, 1'b1, 1'b0, O_MDBSY));
        tbl.push_back(quiet(1'b0, 1'b1, 1'b1, O_FRZB));
        tbl.push_back(quiet(1'b0, 1'b1, 1'b0, O_DONE));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_IDLE));
        // reset while busy aborts without a done pulse
        tbl.push_back(quiet(1'b0, 1'b1, 1'b0, O_MDST));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_MDBSY));
        tbl.push_back(quiet(1'b1, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_IDLE));
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_IDLE));
        for (int i = 0; i < 20; i++) begin
            tbl.push_back(mk(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
        end
        tbl.push_back(quiet(1'b0, 1'b0, 1'b0, O_IDLE));

        for (int i = 0; i < tbl.size(); i++) begin
            sb_t e;
            @(posedge clk);
            #1;
            drive(tbl[i]);
            e.idx = i; e.outs = tbl[i].exp; e.chk_st = st_known; e.st16 = m16; e.st4 = m4;
            sb.push_back(e);
            @(negedge clk);
            check_entry(sb.pop_front());
            if (tbl[i].rst) begin
                m16 = 16'd0; m4 = 4'd0; st_known = 1'b1;
            end else if (!tbl[i].exp[8]) begin
                if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
                if (m4 != 4'hF) m4 = m4 + 4'd1;
            end else begin
                m16 = m16;
            end
        end

        // bounded wait for the completion pulse of a single-cycle muldiv request
        begin
            int done_at;
            done_at = -1;
            @(posedge clk);
            #1;
            drive(quiet(1'b0, 1'b1, 1'b0, O_IDLE));
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (muldiv_done === 1'b1) begin
                    done_at = k;
                    break;
                end
                @(posedge clk);
                #1;
                muldiv_ex = 1'b0;
            end
            checks++;
            if (done_at != 3) begin
                errors++;
                $display("FAIL md_latency: got %0d expected 3", done_at);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
